// File: rtl/key_poll_master.sv
// key_poll_master: polls a key PIO over Avalon-MM at a fixed rate.
// Each poll is debounced, and the module reports the debounced key level
// plus one-cycle press/release pulses. Keys are active-low.
// Optional feature: define KEY_POLL_IRQ_EN to add a sticky press
// interrupt (irq) and its clear strobe (irq_ack).
// Parameter limits: POLL_DIV >= 4, 1 <= DEB_SAMPLES <= 255.
module key_poll_master #(
  parameter int POLL_DIV    = 50000,
  parameter int DEB_SAMPLES = 10,
  parameter int KEY_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  output logic [1:0]       address,
  output logic             read,
  input  logic [31:0]      readdata,
`ifdef KEY_POLL_IRQ_EN
  output logic             irq,
  input  logic             irq_ack,
`endif
  output logic [KEY_W-1:0] key_state,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release
);

  localparam int              TW         = $clog2(POLL_DIV);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(POLL_DIV - 1);
  localparam logic [7:0]      DEB_CNT    = 8'(DEB_SAMPLES);
  localparam logic [KEY_W-1:0] KEYS_UP   = '1;

  typedef enum logic [1:0] {
    S_WAIT,
    S_READ,
    S_CAPTURE,
    S_EVAL
  } state_t;

  state_t           state_q,       state_d;
  logic [TW-1:0]    timer_q,       timer_d;
  logic [KEY_W-1:0] sample_q,      sample_d;
  logic [KEY_W-1:0] cand_q,        cand_d;
  logic [7:0]       cnt_q,         cnt_d;
  logic [KEY_W-1:0] key_state_q,   key_state_d;
  logic [KEY_W-1:0] key_press_q,   key_press_d;
  logic [KEY_W-1:0] key_release_q, key_release_d;

  // Only the low KEY_W bits of the PIO word carry keys; the rest are ignored.
  logic unused_readdata;
  assign unused_readdata = ^readdata;

  // The PIO slave sits at offset 0; read is decoded straight from the state
  // register, so it is high for exactly the READ cycle and never elsewhere.
  assign address     = 2'b00;
  assign read        = (state_q == S_READ);
  assign key_state   = key_state_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;

  // Next-state logic: poll sequencing, debounce and edge detection.
  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no
    // path can leave a variable unassigned and infer a latch.
    state_d       = state_q;
    timer_d       = (timer_q == TIMER_LAST) ? '0 : timer_q + TW'(1);
    sample_d      = sample_q;
    cand_d        = cand_q;
    cnt_d         = cnt_q;
    key_state_d   = key_state_q;
    key_press_d   = '0;
    key_release_d = '0;

    case (state_q)
      // The timer free-runs in every state, so entering READ only on the
      // wrap keeps READ-to-READ spacing at exactly POLL_DIV cycles.
      S_WAIT: begin
        if (timer_q == TIMER_LAST) begin
          state_d = S_READ;
        end
      end

      S_READ: begin
        state_d = S_CAPTURE;
      end

      // Read latency is one cycle: the data belongs to the previous READ.
      S_CAPTURE: begin
        sample_d = readdata[KEY_W-1:0];
        state_d  = S_EVAL;
      end

      S_EVAL: begin
        if (sample_q == cand_q) begin
          if (cnt_q < DEB_CNT) begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          cand_d = sample_q;
          cnt_d  = 8'd1;
        end
        // Acceptance looks at the freshly updated candidate/counter, so with
        // DEB_SAMPLES = 1 a differing sample is accepted in its own EVAL.
        if ((cnt_d == DEB_CNT) && (cand_d != key_state_q)) begin
          key_state_d   = cand_d;
          key_press_d   = key_state_q & ~cand_d;
          key_release_d = ~key_state_q & cand_d;
        end
        state_d = S_WAIT;
      end

      default: begin
        state_d = S_WAIT;
      end
    endcase
  end

  // State registers; reset abandons any poll in flight.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: every flop here holds control or key state, so all are reset;
    // a released key level (all ones) is the safe power-up value.
    if (reset) begin
      state_q       <= S_WAIT;
      timer_q       <= '0;
      sample_q      <= KEYS_UP;
      cand_q        <= KEYS_UP;
      cnt_q         <= 8'd0;
      key_state_q   <= KEYS_UP;
      key_press_q   <= '0;
      key_release_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q       <= state_d;
      timer_q       <= timer_d;
      sample_q      <= sample_d;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      key_state_q   <= key_state_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
    end
  end

`ifdef KEY_POLL_IRQ_EN
  logic irq_q, irq_d;

  assign irq = irq_q;

  // Sticky press interrupt: a visible press pulse wins over a coincident ack.
  always_comb begin
    irq_d = (irq_q & ~irq_ack) | (|key_press_q);
  end

  // Interrupt flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end
`endif

endmodule

// File: doc/key_poll_master.md
KEY_POLL_MASTER -- requirements
Module: key_poll_master

Interface
REQ-001 Parameter POLL_DIV, default 50000, clk cycles between successive PIO reads (min 4).
REQ-002 Parameter DEB_SAMPLES, default 10, consecutive identical samples needed to accept a new key value (min 1, max 255).
REQ-003 Parameter KEY_W, default 4, number of key bits taken from readdata[KEY_W-1:0].
REQ-004 clk  input  1  single clock for all logic.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 address  output  2  Avalon-MM read address toward the key PIO slave; always 0.
REQ-007 read  output  1  Avalon-MM read strobe, one-cycle pulse.
REQ-008 readdata  input  32  PIO read data; fixed read latency 1, no waitrequest.
REQ-009 key_state  output  KEY_W  debounced key level (1 = released, 0 = pressed; keys are active-low).
REQ-010 key_press  output  KEY_W  one-cycle pulse per bit on debounced 1->0 transition.
REQ-011 key_release  output  KEY_W  one-cycle pulse per bit on debounced 0->1 transition.
REQ-012 irq  output  1  press interrupt (present only with KEY_POLL_IRQ_EN).
REQ-013 irq_ack  input  1  interrupt clear strobe (present only with KEY_POLL_IRQ_EN).

Function
REQ-014 FSM states: WAIT, READ, CAPTURE, EVAL; reset state WAIT.
REQ-015 WAIT: poll timer counts 0..POLL_DIV-1; at POLL_DIV-1 timer returns to 0 and FSM goes to READ.
REQ-016 READ: read=1 for exactly this cycle, address=0; next state CAPTURE unconditionally.
REQ-017 CAPTURE: sample register <= readdata[KEY_W-1:0] (data valid one cycle after read); next state EVAL.
REQ-018 EVAL: if sample == candidate, stable counter increments, saturating at DEB_SAMPLES; else candidate <= sample, counter <= 1; next state WAIT.
REQ-019 Acceptance: in EVAL, when counter reaches DEB_SAMPLES (after the update) and candidate != key_state, key_state <= candidate next cycle.
REQ-020 key_press = key_state_old & ~key_state_new; key_release = ~key_state_old & key_state_new; asserted for the single cycle after key_state updates, else 0.
REQ-021 Multiple bits changing in one acceptance pulse together in the same cycle.
REQ-022 With DEB_SAMPLES=1, every differing sample is accepted at its own EVAL.
REQ-023 Poll timer runs during READ/CAPTURE/EVAL; poll period is exactly POLL_DIV cycles READ-to-READ.
REQ-024 read is never asserted outside READ; address stays 0 always.

Reset
REQ-025 On reset assertion, immediately: state=WAIT, timer=0, read=0, address=0, key_state=all ones, candidate=all ones, sample=all ones, counter=0, key_press=0, key_release=0, irq=0.
REQ-026 Reset mid-transaction abandons the read; any readdata arriving after release is ignored.
REQ-027 After reset release, first READ occurs at cycle POLL_DIV.

Configuration
REQ-028 Macro KEY_POLL_IRQ_EN defined: irq set on any key_press bit, held until irq_ack=1; simultaneous press and ack leaves irq=1.
REQ-029 Macro KEY_POLL_IRQ_EN undefined: irq and irq_ack ports and logic absent; all other behaviour identical.

Verification (POLL_DIV=4, DEB_SAMPLES=3, KEY_W=4)
REQ-030 Reset, readdata=0xF -> read pulses every 4 cycles, key_state=0xF, no pulses.
REQ-031 readdata 0xF->0xE held -> key_state=0xE after 3rd EVAL of 0xE, key_press=0x1 for one cycle.
REQ-032 readdata toggling 0xE/0xF each poll -> key_state stays 0xF, no pulses.
REQ-033 from key_state 0xE, readdata=0x9 held -> key_state=0x9, key_press=0x6 and key_release=0x1 in same cycle.
REQ-034 reset asserted one cycle after READ with readdata=0x0 -> all outputs at reset values, key_state=0xF, next read at cycle 4 after release.
REQ-035 KEY_POLL_IRQ_EN: press 0x1 -> irq=1; irq_ack pulse -> irq=0; ack coinciding with new press -> irq stays 1.
